// File: rtl/mining_nonce_sched.sv
// mining_nonce_sched: nonce scheduler and leading-zero target checker that sits between the
// mining control FSM and a SHA-256 hasher. It hands the hasher one nonce per job, captures the
// top DIFF_BITS bits of the digest and walks the nonce space until a hit or until the all-ones
// nonce has been tried.
//
// Optional feature macro: MINING_HIT_CNT_EN
//   defined   -> adds hit_count output; hits are counted and the search only ends in EXHAUSTED.
//   undefined -> the first hit stops the search in FOUND.
//
// Ports:
//   clock        in   1        single clock, all logic on posedge
//   reset        in   1        synchronous, active-high
//   start        in   1        begin search (honoured in IDLE, FOUND, EXHAUSTED)
//   abort        in   1        cancel search, any state -> IDLE
//   hash_done    in   1        hasher result valid pulse
//   HASH         in   256      hasher digest, sampled only on hash_done in WAIT
//   hash_start   out  1        one-cycle job start pulse to the hasher
//   nonce        out  NONCE_W  nonce under test
//   busy         out  1        high in LOAD/ISSUE/WAIT/CHECK
//   found        out  1        hit indication (level in FOUND, or pulse with hit counting)
//   exhausted    out  1        level while in EXHAUSTED
//   found_nonce  out  NONCE_W  nonce of the most recent hit
//   state        out  3        current FSM state (debug)
//   hit_count    out  16       saturating hit counter (MINING_HIT_CNT_EN only)

module mining_nonce_sched #(
  parameter int unsigned NONCE_W    = 32,
  parameter int unsigned DIFF_BITS  = 10,
  parameter int unsigned NONCE_INIT = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               hash_done,
  input  logic [255:0]       HASH,
  output logic               hash_start,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [2:0]         state
`ifdef MINING_HIT_CNT_EN
  ,
  output logic [15:0]        hit_count
`endif
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StLoad      = 3'd1;
  localparam logic [2:0] StIssue     = 3'd2;
  localparam logic [2:0] StWait      = 3'd3;
  localparam logic [2:0] StCheck     = 3'd4;
  localparam logic [2:0] StFound     = 3'd5;
  localparam logic [2:0] StExhausted = 3'd6;

  localparam logic [NONCE_W-1:0] InitNonce = NONCE_W'(NONCE_INIT);

  logic [2:0]           state_q, state_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [DIFF_BITS-1:0] hit_bits_q, hit_bits_d;
  logic                 is_hit;
  logic                 last_nonce;

`ifdef MINING_HIT_CNT_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic        found_pulse_q, found_pulse_d;
`endif

  // Only the leading DIFF_BITS of the digest matter; the rest is sunk here.
  logic unused_hash_low;
  assign unused_hash_low = ^HASH[255-DIFF_BITS:0];

  assign is_hit     = (hit_bits_q == '0);
  assign last_nonce = (nonce_q == '1);

  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    found_nonce_d = found_nonce_q;
    hit_bits_d    = hit_bits_q;
`ifdef MINING_HIT_CNT_EN
    hit_count_d   = hit_count_q;
    found_pulse_d = 1'b0;
`endif

    if (abort) begin
      // Abort wins over everything but reset; nonce and found_nonce are kept.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted: begin
          if (start) begin
            state_d = StLoad;
`ifdef MINING_HIT_CNT_EN
            hit_count_d = '0;
`endif
          end
        end
        StLoad: begin
          nonce_d = InitNonce;
          state_d = StIssue;
        end
        StIssue: begin
          state_d = StWait;
        end
        StWait: begin
          // No timeout: a hasher that never answers parks the FSM here until abort/reset.
          if (hash_done) begin
            hit_bits_d = HASH[255 -: DIFF_BITS];
            state_d    = StCheck;
          end
        end
        StCheck: begin
`ifdef MINING_HIT_CNT_EN
          // Record the hit and keep searching; only nonce exhaustion ends the run.
          if (is_hit) begin
            found_nonce_d = nonce_q;
            found_pulse_d = 1'b1;
            if (hit_count_q != 16'hFFFF) begin
              hit_count_d = hit_count_q + 16'd1;
            end
          end
          if (last_nonce) begin
            state_d = StExhausted;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = StIssue;
          end
`else
          if (is_hit) begin
            found_nonce_d = nonce_q;
            state_d       = StFound;
          end else if (last_nonce) begin
            // The all-ones nonce was the last candidate; do not wrap.
            state_d = StExhausted;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = StIssue;
          end
`endif
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      nonce_q       <= InitNonce;
      found_nonce_q <= '0;
      hit_bits_q    <= '1;
`ifdef MINING_HIT_CNT_EN
      hit_count_q   <= '0;
      found_pulse_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      found_nonce_q <= found_nonce_d;
      hit_bits_q    <= hit_bits_d;
`ifdef MINING_HIT_CNT_EN
      hit_count_q   <= hit_count_d;
      found_pulse_q <= found_pulse_d;
`endif
    end
  end

  // abort in ISSUE must kill the job request in the same cycle.
  assign hash_start  = (state_q == StIssue) && !abort;
  assign nonce       = nonce_q;
  assign busy        = (state_q == StLoad) || (state_q == StIssue) ||
                       (state_q == StWait) || (state_q == StCheck);
  assign exhausted   = (state_q == StExhausted);
  assign found_nonce = found_nonce_q;
  assign state       = state_q;

`ifdef MINING_HIT_CNT_EN
  assign found     = found_pulse_q;
  assign hit_count = hit_count_q;
`else
  assign found     = (state_q == StFound);
`endif

endmodule

// File: tb/tb_mining_nonce_sched.sv
module tb_mining_nonce_sched;

  localparam logic [255:0] HitPat  = {16'h003F, {240{1'b1}}};  // exactly 10 leading zeros
  localparam logic [255:0] MissTop = {1'b1, 255'b0};
  localparam logic [255:0] Miss9   = {16'h0040, 240'b0};       // 9 leading zeros: one short

  logic         clock;
  logic         reset;
  logic         start_v, abort_v, hash_done_v;
  logic [255:0] hash_v;
  int           sel;

  int total;
  int bad;
  int found_pulses;
  int pulses;
  logic [31:0] exp_q[$];
  logic [31:0] last_found_a;

  // DUT a: default parameters
  logic        a_start, a_abort, a_hash_done, a_hash_start, a_busy, a_found, a_exh;
  logic [31:0] a_nonce, a_fnonce;
  logic [2:0]  a_state;
  // DUT b: NONCE_W=4, NONCE_INIT=14
  logic        b_start, b_abort, b_hash_done, b_hash_start, b_busy, b_found, b_exh;
  logic [3:0]  b_nonce, b_fnonce;
  logic [2:0]  b_state;
`ifdef MINING_HIT_CNT_EN
  logic [15:0] a_hc, b_hc, c_hc;
  logic        c_start, c_abort, c_hash_done, c_hash_start, c_busy, c_found, c_exh;
  logic [2:0]  c_nonce, c_fnonce;
  logic [2:0]  c_state;
`endif

  logic        obs_hs, obs_busy, obs_found, obs_exh;
  logic [31:0] obs_nonce, obs_fnonce;
  logic [2:0]  obs_state;
  logic [15:0] obs_hc;

  assign a_start     = start_v && (sel == 0);
  assign a_abort     = abort_v && (sel == 0);
  assign a_hash_done = hash_done_v && (sel == 0);
  assign b_start     = start_v && (sel == 1);
  assign b_abort     = abort_v && (sel == 1);
  assign b_hash_done = hash_done_v && (sel == 1);

  mining_nonce_sched u_a (
    .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
    .hash_done(a_hash_done), .HASH(hash_v), .hash_start(a_hash_start), .nonce(a_nonce),
    .busy(a_busy), .found(a_found), .exhausted(a_exh), .found_nonce(a_fnonce),
    .state(a_state)
`ifdef MINING_HIT_CNT_EN
    , .hit_count(a_hc)
`endif
  );

  mining_nonce_sched #(.NONCE_W(4), .DIFF_BITS(10), .NONCE_INIT(14)) u_b (
    .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
    .hash_done(b_hash_done), .HASH(hash_v), .hash_start(b_hash_start), .nonce(b_nonce),
    .busy(b_busy), .found(b_found), .exhausted(b_exh), .found_nonce(b_fnonce),
    .state(b_state)
`ifdef MINING_HIT_CNT_EN
    , .hit_count(b_hc)
`endif
  );

`ifdef MINING_HIT_CNT_EN
  assign c_start     = start_v && (sel == 2);
  assign c_abort     = abort_v && (sel == 2);
  assign c_hash_done = hash_done_v && (sel == 2);

  mining_nonce_sched #(.NONCE_W(3), .DIFF_BITS(10), .NONCE_INIT(0)) u_c (
    .clock(clock), .reset(reset), .start(c_start), .abort(c_abort),
    .hash_done(c_hash_done), .HASH(hash_v), .hash_start(c_hash_start), .nonce(c_nonce),
    .busy(c_busy), .found(c_found), .exhausted(c_exh), .found_nonce(c_fnonce),
    .state(c_state), .hit_count(c_hc)
  );
`endif

  always_comb begin
    obs_hs = a_hash_start; obs_busy = a_busy; obs_found = a_found; obs_exh = a_exh;
    obs_nonce = a_nonce; obs_fnonce = a_fnonce; obs_state = a_state; obs_hc = '0;
`ifdef MINING_HIT_CNT_EN
    obs_hc = a_hc;
`endif
    if (sel == 1) begin
      obs_hs = b_hash_start; obs_busy = b_busy; obs_found = b_found; obs_exh = b_exh;
      obs_nonce = 32'(b_nonce); obs_fnonce = 32'(b_fnonce); obs_state = b_state;
`ifdef MINING_HIT_CNT_EN
      obs_hc = b_hc;
`endif
    end
`ifdef MINING_HIT_CNT_EN
    if (sel == 2) begin
      obs_hs = c_hash_start; obs_busy = c_busy; obs_found = c_found; obs_exh = c_exh;
      obs_nonce = 32'(c_nonce); obs_fnonce = 32'(c_fnonce); obs_state = c_state;
      obs_hc = c_hc;
    end
`endif
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a search and plays hasher for n_jobs jobs. hits[j] selects a hit digest for job j.
  // Returns one cycle after the last hash_done (DUT in CHECK).
  task automatic run_jobs(input int first_n, input int n_jobs, input logic [63:0] hits,
                          input string tag);
    int k;
    logic [31:0] exp_n;
    for (int j = 0; j < n_jobs; j++) exp_q.push_back(32'(first_n + j));
    found_pulses = 0;
    pulses = 0;
    start_v = 1'b1;
    k = 0;
    tick();
    k++;
    start_v = 1'b0;
    for (int j = 0; j < n_jobs; j++) begin
      while (!obs_hs && k < 16) begin
        tick();
        k++;
        if (obs_found) found_pulses++;
      end
      total++;
      if (obs_hs !== 1'b1) begin
        bad++;
        $display("FAIL %s job%0d hash_start: got %b want 1 within 16 cycles", tag, j, obs_hs);
        exp_q.delete();
        return;
      end
      pulses++;
      total++;
      if (k != 2) begin
        bad++;
        $display("FAIL %s job%0d gap: got %0d want 2", tag, j, k);
      end
      exp_n = exp_q.pop_front();
      total++;
      if (obs_nonce !== exp_n) begin
        bad++;
        $display("FAIL %s job%0d nonce: got %0d want %0d", tag, j, obs_nonce, exp_n);
      end
      tick();
      total++;
      if (obs_state !== 3'd3 || obs_hs !== 1'b0) begin
        bad++;
        $display("FAIL %s job%0d wait: got state=%0d hs=%b want 3/0", tag, j, obs_state, obs_hs);
      end
      tick();
      total++;
      if (obs_nonce !== exp_n || obs_state !== 3'd3) begin
        bad++;
        $display("FAIL %s job%0d hold: got nonce=%0d state=%0d want %0d/3", tag, j, obs_nonce,
                 obs_state, exp_n);
      end
      hash_done_v = 1'b1;
      hash_v = hits[j] ? HitPat : ((j % 2) == 1 ? Miss9 : MissTop);
      k = 0;
      tick();
      k++;
      hash_done_v = 1'b0;
      hash_v = '0;
    end
  endtask

  task automatic count_idle_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (obs_hs) n++;
    end
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b1;
    tick();
    total++;
    if (a_state !== 3'd0 || a_found !== 1'b0 || a_exh !== 1'b0 || a_hash_start !== 1'b0 ||
        a_nonce !== 32'd0 || a_busy !== 1'b0 || a_fnonce !== 32'd0) begin
      bad++;
      $display("FAIL reset_a: got st=%0d f=%b e=%b hs=%b n=%0d b=%b fn=%0d want all 0",
               a_state, a_found, a_exh, a_hash_start, a_nonce, a_busy, a_fnonce);
    end
    total++;
    if (b_state !== 3'd0 || b_nonce !== 4'd14 || b_fnonce !== 4'd0) begin
      bad++;
      $display("FAIL reset_b: got st=%0d n=%0d fn=%0d want 0/14/0", b_state, b_nonce, b_fnonce);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic check_hit_end(input string tag, input logic [31:0] want_fn, input int want_p);
    int n;
    total++;
    if (obs_found !== 1'b0 || obs_state !== 3'd4) begin
      bad++;
      $display("FAIL %s check: got found=%b state=%0d want 0/4", tag, obs_found, obs_state);
    end
    tick();
    total++;
    if (obs_found !== 1'b1 || obs_fnonce !== want_fn || obs_busy !== 1'b0 ||
        obs_state !== 3'd5) begin
      bad++;
      $display("FAIL %s found: got f=%b fn=%0d b=%b st=%0d want 1/%0d/0/5", tag, obs_found,
               obs_fnonce, obs_busy, obs_state, want_fn);
    end
    total++;
    if (pulses != want_p) begin
      bad++;
      $display("FAIL %s pulses: got %0d want %0d", tag, pulses, want_p);
    end
    count_idle_pulses(3, n);
    total++;
    if (n != 0 || obs_found !== 1'b1) begin
      bad++;
      $display("FAIL %s hold: got pulses=%0d found=%b want 0/1", tag, n, obs_found);
    end
  endtask

  task automatic test_first_hit();
    sel = 0;
    run_jobs(0, 1, 64'h1, "first_hit");
    check_hit_end("first_hit", 32'd0, 1);
    last_found_a = 32'd0;
  endtask

  task automatic test_miss_then_hit();
    sel = 0;
    run_jobs(0, 6, 64'h20, "miss_hit");
    check_hit_end("miss_hit", 32'd5, 6);
    last_found_a = 32'd5;
  endtask

  task automatic test_exhaust();
    int n;
    sel = 1;
    run_jobs(14, 2, 64'h0, "exhaust");
    total++;
    if (obs_exh !== 1'b0) begin
      bad++;
      $display("FAIL exhaust early: got %b want 0", obs_exh);
    end
    tick();
    total++;
    if (obs_exh !== 1'b1 || obs_nonce !== 32'd15 || obs_state !== 3'd6 || obs_busy !== 1'b0 ||
        obs_found !== 1'b0) begin
      bad++;
      $display("FAIL exhaust end: got e=%b n=%0d st=%0d b=%b f=%b want 1/15/6/0/0", obs_exh,
               obs_nonce, obs_state, obs_busy, obs_found);
    end
    count_idle_pulses(3, n);
    total++;
    if (n != 0 || obs_nonce !== 32'd15 || obs_exh !== 1'b1) begin
      bad++;
      $display("FAIL exhaust nowrap: got pulses=%0d n=%0d e=%b want 0/15/1", n, obs_nonce, obs_exh);
    end
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    total++;
    if (obs_state !== 3'd1 || obs_exh !== 1'b0) begin
      bad++;
      $display("FAIL exhaust restart: got st=%0d e=%b want 1/0", obs_state, obs_exh);
    end
    tick();
    total++;
    if (obs_nonce !== 32'd14 || obs_hs !== 1'b1) begin
      bad++;
      $display("FAIL exhaust reload: got n=%0d hs=%b want 14/1", obs_nonce, obs_hs);
    end
    abort_v = 1'b1;
    tick();
    abort_v = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    sel = 0;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    total++;
    if (obs_state !== 3'd1 || obs_found !== 1'b0 || obs_busy !== 1'b1) begin
      bad++;
      $display("FAIL abort load: got st=%0d f=%b b=%b want 1/0/1", obs_state, obs_found, obs_busy);
    end
    tick();
    abort_v = 1'b1;
    #1;
    total++;
    if (obs_hs !== 1'b0 || obs_state !== 3'd2) begin
      bad++;
      $display("FAIL abort issue: got hs=%b st=%0d want 0/2", obs_hs, obs_state);
    end
    tick();
    abort_v = 1'b0;
    total++;
    if (obs_state !== 3'd0 || obs_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort idle: got st=%0d b=%b want 0/0", obs_state, obs_busy);
    end
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    tick();
    total++;
    if (obs_hs !== 1'b1 || obs_nonce !== 32'd0) begin
      bad++;
      $display("FAIL abort reissue: got hs=%b n=%0d want 1/0", obs_hs, obs_nonce);
    end
    tick();
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    total++;
    if (obs_state !== 3'd3) begin
      bad++;
      $display("FAIL start_busy: got st=%0d want 3", obs_state);
    end
    abort_v = 1'b1;
    tick();
    abort_v = 1'b0;
    hash_done_v = 1'b1;
    hash_v = HitPat;
    tick();
    hash_done_v = 1'b0;
    hash_v = '0;
    total++;
    if (obs_state !== 3'd0 || obs_found !== 1'b0 || obs_fnonce !== last_found_a) begin
      bad++;
      $display("FAIL abort wait: got st=%0d f=%b fn=%0d want 0/0/%0d", obs_state, obs_found,
               obs_fnonce, last_found_a);
    end
    abort_v = 1'b1;
    count_idle_pulses(4, n);
    abort_v = 1'b0;
    total++;
    if (n != 0 || obs_state !== 3'd0 || obs_found !== 1'b0) begin
      bad++;
      $display("FAIL abort quiet: got pulses=%0d st=%0d f=%b want 0/0/0", n, obs_state, obs_found);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (obs_state !== 3'd0 || obs_nonce !== 32'd0 || obs_fnonce !== 32'd0 || obs_busy !== 1'b0 ||
        obs_hs !== 1'b0 || obs_found !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got st=%0d n=%0d fn=%0d b=%b hs=%b f=%b want all 0", obs_state,
               obs_nonce, obs_fnonce, obs_busy, obs_hs, obs_found);
    end
    hash_done_v = 1'b1;
    hash_v = HitPat;
    tick();
    hash_done_v = 1'b0;
    hash_v = '0;
    tick();
    total++;
    if (obs_state !== 3'd0 || obs_found !== 1'b0) begin
      bad++;
      $display("FAIL reset_stale: got st=%0d f=%b want 0/0", obs_state, obs_found);
    end
  endtask

`ifdef MINING_HIT_CNT_EN
  task automatic test_hit_count();
    sel = 2;
    run_jobs(0, 8, 64'h44, "hit_count");
    total++;
    if (found_pulses != 2) begin
      bad++;
      $display("FAIL hit_count pulses: got %0d want 2", found_pulses);
    end
    tick();
    total++;
    if (obs_exh !== 1'b1 || obs_hc !== 16'd2 || obs_fnonce !== 32'd6 || obs_nonce !== 32'd7 ||
        obs_found !== 1'b0) begin
      bad++;
      $display("FAIL hit_count end: got e=%b hc=%0d fn=%0d n=%0d f=%b want 1/2/6/7/0", obs_exh,
               obs_hc, obs_fnonce, obs_nonce, obs_found);
    end
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    total++;
    if (obs_hc !== 16'd0 || obs_exh !== 1'b0) begin
      bad++;
      $display("FAIL hit_count clear: got hc=%0d e=%b want 0/0", obs_hc, obs_exh);
    end
    abort_v = 1'b1;
    tick();
    abort_v = 1'b0;
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    sel = 0;
    reset = 1'b1;
    start_v = 1'b0;
    abort_v = 1'b0;
    hash_done_v = 1'b0;
    hash_v = '0;
    last_found_a = 32'd0;
    test_reset();
`ifndef MINING_HIT_CNT_EN
    test_first_hit();
    test_miss_then_hit();
`endif
    test_exhaust();
    test_abort();
`ifdef MINING_HIT_CNT_EN
    test_hit_count();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
